// File: rtl/ahb_wrr_arbiter.sv
// Weighted round-robin AHB bus arbiter: a master keeps the bus for up to
// `weight` consecutive transactions, and handover happens with no idle cycle.
module ahb_wrr_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int WEIGHT_BIT = 4,
    parameter int MIDX_BIT   = $clog2(MASTER_NUM)
) (
    input  logic                             hclk,
    input  logic                             hreset_n,
    input  logic [MASTER_NUM-1:0]            hreq,
    input  logic [3*MASTER_NUM-1:0]          hburst,
    input  logic                             hwait,
    input  logic [MASTER_NUM*WEIGHT_BIT-1:0] weight,
    input  logic                             weight_load,
    output logic [MASTER_NUM-1:0]            hgrant,
    output logic                             hsel,
    output logic [MIDX_BIT-1:0]              hmaster,
    output logic                             hlast
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [MASTER_NUM-1:0]   owner_q, owner_d;
    logic [MIDX_BIT-1:0]     midx_q, midx_d;
    logic [3:0]              count_q, count_d;
    logic [3:0]              lenm1_q, lenm1_d;
    logic                    incr_q, incr_d;
    logic [WEIGHT_BIT-1:0]   weight_q [MASTER_NUM];
    logic [WEIGHT_BIT-1:0]   weight_d [MASTER_NUM];
    logic [WEIGHT_BIT-1:0]   credit_q [MASTER_NUM];
    logic [WEIGHT_BIT-1:0]   credit_d [MASTER_NUM];

    logic [2:0]              burst_s  [MASTER_NUM];
    logic [WEIGHT_BIT-1:0]   weight_s [MASTER_NUM];
    logic                    sel_s;
    logic                    last_s;
    logic                    grant_s;
    logic [MIDX_BIT-1:0]     next_s;
    logic [WEIGHT_BIT-1:0]   cred_dec_s;

    // First requester found scanning upward from (from + 1), wrapping around.
    function automatic logic [MIDX_BIT-1:0] rr_pick(input logic [MASTER_NUM-1:0] req,
                                                    input logic [MIDX_BIT-1:0]   from);
        logic [MIDX_BIT-1:0] pick;
        logic [MIDX_BIT-1:0] cand;
        logic                found;
        pick  = from;
        found = 1'b0;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            cand = MIDX_BIT'((int'(from) + k) % MASTER_NUM);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Returns {incr, beats-1}; INCR is capped at 16 beats.
    function automatic logic [4:0] burst_decode(input logic [2:0] code);
        logic [4:0] res;
        case (code)
            3'b000:         res = {1'b0, 4'd0};
            3'b001:         res = {1'b1, 4'd15};
            3'b010, 3'b011: res = {1'b0, 4'd3};
            3'b100, 3'b101: res = {1'b0, 4'd7};
            default:        res = {1'b0, 4'd15};
        endcase
        return res;
    endfunction

    function automatic logic [WEIGHT_BIT-1:0] reload_val(input logic [WEIGHT_BIT-1:0] w);
        return (w == {WEIGHT_BIT{1'b0}}) ? WEIGHT_BIT'(1'b1) : w;
    endfunction

    // Unpack per-master input buses.
    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            burst_s[i]  = hburst[i*3 +: 3];
            weight_s[i] = weight[i*WEIGHT_BIT +: WEIGHT_BIT];
        end
    end

    assign sel_s      = |owner_q;
    assign last_s     = sel_s && ((count_q == lenm1_q) || (incr_q && !hreq[midx_q]));
    assign cred_dec_s = (credit_q[midx_q] == {WEIGHT_BIT{1'b0}}) ? {WEIGHT_BIT{1'b0}}
                                                                  : credit_q[midx_q] - WEIGHT_BIT'(1'b1);

    assign hgrant  = owner_q & {MASTER_NUM{~hwait}};
    assign hsel    = sel_s;
    assign hmaster = midx_q;
    assign hlast   = last_s;

    // Next-state: arbitration, beat counting, credit and weight bookkeeping.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        midx_d   = midx_q;
        count_d  = count_q;
        lenm1_d  = lenm1_q;
        incr_d   = incr_q;
        credit_d = credit_q;
        grant_s  = 1'b0;
        next_s   = midx_q;
        for (int i = 0; i < MASTER_NUM; i++) begin
            weight_d[i] = weight_load ? weight_s[i] : weight_q[i];
        end

        case (state_q)
            IDLE: begin
                if (|hreq) begin
                    grant_s = 1'b1;
                    next_s  = rr_pick(hreq, midx_q);
                end else begin
                    owner_d = {MASTER_NUM{1'b0}};
                end
            end
            BURST: begin
                if (hwait) begin
                    count_d = count_q;
                end else if (last_s) begin
                    if ((cred_dec_s != {WEIGHT_BIT{1'b0}}) && hreq[midx_q]) begin
                        credit_d[midx_q] = cred_dec_s;
                        grant_s          = 1'b1;
                        next_s           = midx_q;
                    end else begin
                        // weight_d already carries a coincident weight_load
                        credit_d[midx_q] = reload_val(weight_d[midx_q]);
                        if (|hreq) begin
                            grant_s = 1'b1;
                            next_s  = rr_pick(hreq, midx_q);
                        end else begin
                            state_d = IDLE;
                            owner_d = {MASTER_NUM{1'b0}};
                        end
                    end
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = {MASTER_NUM{1'b0}};
            end
        endcase

        if (grant_s) begin
            state_d           = BURST;
            owner_d           = {{(MASTER_NUM-1){1'b0}}, 1'b1} << next_s;
            midx_d            = next_s;
            count_d           = 4'd0;
            {incr_d, lenm1_d} = burst_decode(burst_s[next_s]);
        end else begin
            midx_d = midx_d;
        end
    end

    // State registers with asynchronous reset abandoning any burst.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= IDLE;
            owner_q <= {MASTER_NUM{1'b0}};
            midx_q  <= MIDX_BIT'(MASTER_NUM - 1);
            count_q <= 4'd0;
            lenm1_q <= 4'd0;
            incr_q  <= 1'b0;
            for (int i = 0; i < MASTER_NUM; i++) begin
                weight_q[i] <= WEIGHT_BIT'(1'b1);
                credit_q[i] <= WEIGHT_BIT'(1'b1);
            end
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            midx_q  <= midx_d;
            count_q <= count_d;
            lenm1_q <= lenm1_d;
            incr_q  <= incr_d;
            for (int i = 0; i < MASTER_NUM; i++) begin
                weight_q[i] <= weight_d[i];
                credit_q[i] <= credit_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
// Bench for ahb_wrr_arbiter: directed scenarios plus random traffic, each cycle
// compared with a transaction-level model of the arbitration rules.
module tb_ahb_wrr_arbiter;

    logic        hclk        = 1'b0;
    logic        hreset_n    = 1'b0;
    logic [3:0]  hreq        = 4'b0000;
    logic [11:0] hburst      = 12'h000;
    logic        hwait       = 1'b0;
    logic [15:0] weight      = 16'h0000;
    logic        weight_load = 1'b0;
    logic [3:0]  hgrant;
    logic        hsel;
    logic [1:0]  hmaster;
    logic        hlast;
    logic [7:0]  obs;
    logic [7:0]  exp_v;

    int n_checks = 0;
    int n_fails  = 0;

    // model: owner (-1 = none), last owner, completed beats, burst length
    int m_owner, m_last, m_beats, m_blen;
    bit m_incr;
    int m_credit [4];
    int m_weight [4];

    logic [3:0] g_log [64];
    logic       l_log [64];
    logic       s_log [64];

    always #5 hclk = ~hclk;

    assign obs = {hgrant, hsel, hmaster, hlast};

    ahb_wrr_arbiter dut (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
        .hwait(hwait), .weight(weight), .weight_load(weight_load),
        .hgrant(hgrant), .hsel(hsel), .hmaster(hmaster), .hlast(hlast)
    );

    function automatic void model_reset();
        m_owner = -1; m_last = 3; m_beats = 0; m_blen = 1; m_incr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_credit[i] = 1;
            m_weight[i] = 1;
        end
    endfunction

    function automatic logic [7:0] model_exp();
        logic [3:0] g;
        logic s, l;
        g = 4'b0000; s = 1'b0; l = 1'b0;
        if (m_owner >= 0) begin
            s = 1'b1;
            if (!hwait) g[m_owner] = 1'b1;
            l = (m_beats == m_blen - 1) || (m_incr && !hreq[m_owner]);
        end
        return {g, s, 2'(m_last), l};
    endfunction

    function automatic int pick(int from);
        for (int k = 1; k <= 4; k++) begin
            if (hreq[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_grant(int m);
        logic [2:0] code;
        code    = hburst[m*3 +: 3];
        m_owner = m;
        m_last  = m;
        m_beats = 0;
        m_incr  = (code == 3'b001);
        if (code == 3'b000)      m_blen = 1;
        else if (code == 3'b001) m_blen = 16;
        else if (code <= 3'b011) m_blen = 4;
        else if (code <= 3'b101) m_blen = 8;
        else                     m_blen = 16;
    endfunction

    function automatic void model_step();
        int  nw [4];
        int  o, c;
        bit  fin;
        fin = model_exp()[0];
        for (int i = 0; i < 4; i++) nw[i] = weight_load ? int'(weight[i*4 +: 4]) : m_weight[i];
        if (m_owner < 0) begin
            if (hreq != 4'b0000) model_grant(pick(m_last));
        end else if (!hwait) begin
            if (fin) begin
                o = m_owner;
                c = (m_credit[o] > 0) ? m_credit[o] - 1 : 0;
                if (c > 0 && hreq[o]) begin
                    m_credit[o] = c;
                    model_grant(o);
                end else begin
                    m_credit[o] = (nw[o] == 0) ? 1 : nw[o];
                    if (hreq != 4'b0000) model_grant(pick(o));
                    else m_owner = -1;
                end
            end else begin
                m_beats++;
            end
        end
        for (int i = 0; i < 4; i++) m_weight[i] = nw[i];
    endfunction

    task automatic tick();
        @(posedge hclk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        hreset_n = 1'b0; hreq = 4'b0000; hburst = 12'h000; hwait = 1'b0; weight_load = 1'b0;
        model_reset();
        repeat (2) @(posedge hclk);
        #1;
        hreset_n = 1'b1;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        hreq = 4'b1111;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge hclk);
            n_checks++;
            if (obs !== 8'b0000_0_11_0) begin
                n_fails++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", c, obs, 8'b0000_0_11_0);
            end
        end
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        hreq = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL reset_idle cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_single();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            hreq = (c == 0) ? 4'b0001 : 4'b0000;
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL single cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            s_log[c] = hsel; g_log[c] = hgrant; l_log[c] = hlast;
            tick();
        end
        n_checks++;
        if ({g_log[0], g_log[1], l_log[1], s_log[2]} !== {4'b0000, 4'b0001, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL single_seq: got g0=%b g1=%b hlast1=%b hsel2=%b expected 0000 0001 1 0",
                     g_log[0], g_log[1], l_log[1], s_log[2]);
        end
    endtask

    task automatic test_incr4_handover();
        apply_reset();
        hburst = 12'b000_000_000_011;
        hreq   = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL incr4 cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            g_log[c] = hgrant; l_log[c] = hlast;
            tick();
        end
        n_checks++;
        if ({g_log[1], g_log[2], g_log[3], g_log[4], g_log[5]} !== 20'h11112) begin
            n_fails++;
            $display("FAIL incr4_grants: got %h expected 11112",
                     {g_log[1], g_log[2], g_log[3], g_log[4], g_log[5]});
        end
        n_checks++;
        if ({l_log[1], l_log[2], l_log[3], l_log[4]} !== 4'b0001) begin
            n_fails++;
            $display("FAIL incr4_hlast: got %b expected 0001", {l_log[1], l_log[2], l_log[3], l_log[4]});
        end
    endtask

    task automatic test_wait();
        int beats, lasts, waitok;
        apply_reset();
        hburst = 12'b000_000_000_101;
        hreq   = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            hwait = (c >= 4 && c <= 6);
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL wait cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            g_log[c] = hgrant; l_log[c] = hlast; s_log[c] = hsel;
            tick();
        end
        hwait = 1'b0;
        beats = 0; lasts = 0; waitok = 0;
        for (int c = 1; c < 12; c++) begin
            if (g_log[c] == 4'b0001) beats++;
            if (l_log[c]) lasts++;
            if (c >= 4 && c <= 6 && g_log[c] == 4'b0000 && s_log[c]) waitok++;
        end
        n_checks++;
        if (beats !== 8 || lasts !== 1 || waitok !== 3 || l_log[11] !== 1'b1) begin
            n_fails++;
            $display("FAIL wait_burst: got beats=%0d hlasts=%0d waitcycles=%0d hlast11=%b expected 8 1 3 1",
                     beats, lasts, waitok, l_log[11]);
        end
    endtask

    task automatic test_weights();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            weight_load = (c == 0);
            weight      = 16'h0013;
            hreq        = (c == 0) ? 4'b0000 : 4'b0011;
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL weights cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            g_log[c] = hgrant;
            tick();
        end
        weight_load = 1'b0;
        n_checks++;
        if ({g_log[4], g_log[5], g_log[6], g_log[7], g_log[8], g_log[9], g_log[10], g_log[11]} !== 32'h11121112) begin
            n_fails++;
            $display("FAIL weights_seq: got %h expected 11121112",
                     {g_log[4], g_log[5], g_log[6], g_log[7], g_log[8], g_log[9], g_log[10], g_log[11]});
        end
    endtask

    task automatic test_incr();
        int beats2, lasts2, first_ok;
        apply_reset();
        hburst = 12'b000_001_000_000;
        for (int c = 0; c < 26; c++) begin
            if (c <= 4)      hreq = 4'b1100;
            else if (c == 5) hreq = 4'b1000;
            else if (c == 6) hreq = 4'b1100;
            else             hreq = 4'b0100;
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL incr cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            g_log[c] = hgrant; l_log[c] = hlast;
            tick();
        end
        first_ok = 0;
        for (int c = 1; c <= 5; c++) if (g_log[c] == 4'b0100 && l_log[c] == (c == 5)) first_ok++;
        n_checks++;
        if (first_ok !== 5 || g_log[6] !== 4'b1000) begin
            n_fails++;
            $display("FAIL incr_drop: got okbeats=%0d g6=%b expected 5 1000", first_ok, g_log[6]);
        end
        beats2 = 0; lasts2 = 0;
        for (int c = 7; c <= 22; c++) begin
            if (g_log[c] == 4'b0100) beats2++;
            if (l_log[c]) lasts2++;
        end
        n_checks++;
        if (beats2 !== 16 || lasts2 !== 1 || l_log[22] !== 1'b1) begin
            n_fails++;
            $display("FAIL incr_cap: got beats=%0d hlasts=%0d hlast22=%b expected 16 1 1", beats2, lasts2, l_log[22]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        hburst = 12'b000_000_000_110;
        hreq   = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL wrap16 cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c < 7) tick();
        end
        #2;
        hreset_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'b0000_0_11_0) begin
            n_fails++;
            $display("FAIL reset_async: got %b expected %b", obs, 8'b0000_0_11_0);
        end
        model_reset();
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        hburst = 12'h000;
        hreq   = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL post_reset cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            g_log[c] = hgrant;
            tick();
        end
        n_checks++;
        if ({g_log[0], g_log[1]} !== 8'b0000_0001) begin
            n_fails++;
            $display("FAIL post_reset_first: got %b %b expected 0000 0001", g_log[0], g_log[1]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            hreq        = 4'($urandom_range(0, 15));
            hburst      = 12'($urandom);
            hwait       = ($urandom_range(0, 3) == 0);
            weight_load = ($urandom_range(0, 15) == 0);
            weight      = 16'($urandom);
            @(negedge hclk);
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) begin
                n_fails++;
                $display("FAIL random cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            tick();
        end
        weight_load = 1'b0;
        hwait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr4_handover();
        test_wait();
        test_weights();
        test_incr();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
